// File: rtl/block_nest_checker_if.sv
// Character stream in, nesting status out, for block_nest_checker.
interface block_nest_checker_if #(
  parameter int unsigned DEPTH_W = 4
);
  logic               clear;
  logic               in_valid;
  logic [7:0]         in_char;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               error;
  logic               err_ovf;

  // Stream source side
  modport master (
    output clear, in_valid, in_char,
    input  depth, balanced, error, err_ovf
  );

  // Checker side
  modport slave (
    input  clear, in_valid, in_char,
    output depth, balanced, error, err_ovf
  );
endinterface

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker over a delimited ASCII word stream.
module block_nest_checker #(
  parameter int unsigned DEPTH_W   = 4,
  parameter logic [7:0]  DELIM     = 8'h20,
  parameter bit          CASE_SENS = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  block_nest_checker_if.slave bus
);

  localparam int unsigned        SUM_W     = DEPTH_W + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [7:0] CH_B = 8'h62;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_N = 8'h6E;
  localparam logic [7:0] CH_D = 8'h64;

  typedef enum logic [3:0] {
    S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN,
    S_E, S_EN, S_END, S_OTHER, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               error_q, error_d;
  logic               err_ovf_q, err_ovf_d;
  logic               balanced_q, balanced_d;

  logic [7:0]         char_n;
  logic [SUM_W-1:0]   pend;
  logic [SUM_W-1:0]   sum;

  // Fold upper case onto lower case when keywords are case-insensitive
  always_comb begin
    char_n = bus.in_char;
    if (!CASE_SENS && (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A)) begin
      char_n = bus.in_char | 8'h20;
    end
  end

  // Word FSM, depth commit, error capture and balance look-ahead
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    error_d    = error_q;
    err_ovf_d  = err_ovf_q;
    pend       = '0;
    sum        = '0;
    balanced_d = balanced_q;

    if (bus.clear) begin
      state_d   = S_IDLE;
      depth_d   = '0;
      error_d   = 1'b0;
      err_ovf_d = 1'b0;
    end else if (bus.in_valid && (state_q != S_ERR)) begin
      if (bus.in_char == DELIM) begin
        // Delimiter commits the finished word
        state_d = S_IDLE;
        if (state_q == S_BEGIN) begin
          if (depth_q == DEPTH_MAX) begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            err_ovf_d = 1'b1;
          end else begin
            depth_d = depth_q + DEPTH_ONE;
          end
        end else if (state_q == S_END) begin
          if (depth_q == '0) begin
            state_d   = S_ERR;
            error_d   = 1'b1;
            err_ovf_d = 1'b0;
          end else begin
            depth_d = depth_q - DEPTH_ONE;
          end
        end
      end else begin
        state_d = S_OTHER;
        unique case (state_q)
          S_IDLE: begin
            if (char_n == CH_B)      state_d = S_B;
            else if (char_n == CH_E) state_d = S_E;
          end
          S_B:    if (char_n == CH_E) state_d = S_BE;
          S_BE:   if (char_n == CH_G) state_d = S_BEG;
          S_BEG:  if (char_n == CH_I) state_d = S_BEGI;
          S_BEGI: if (char_n == CH_N) state_d = S_BEGIN;
          S_E:    if (char_n == CH_N) state_d = S_EN;
          S_EN:   if (char_n == CH_D) state_d = S_END;
          default: state_d = S_OTHER;
        endcase
      end
    end

    // A word still pending counts toward balance but not toward depth
    if (state_d == S_BEGIN)    pend = SUM_W'(1);
    else if (state_d == S_END) pend = {SUM_W{1'b1}};
    sum        = {1'b0, depth_d} + pend;
    balanced_d = !error_d && (sum == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      depth_q    <= '0;
      error_q    <= 1'b0;
      err_ovf_q  <= 1'b0;
      balanced_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      error_q    <= error_d;
      err_ovf_q  <= err_ovf_d;
      balanced_q <= balanced_d;
    end
  end

  assign bus.depth    = depth_q;
  assign bus.balanced = balanced_q;
  assign bus.error    = error_q;
  assign bus.err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench: three checker instances (default, DEPTH_W=2, case-sensitive) share one stream.
module tb_block_nest_checker;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_char;

  int n_checks;
  int n_fail;

  block_nest_checker_if #(.DEPTH_W(4)) if0 ();
  block_nest_checker_if #(.DEPTH_W(2)) if1 ();
  block_nest_checker_if #(.DEPTH_W(4)) if2 ();

  assign if0.clear = clear;  assign if0.in_valid = in_valid;  assign if0.in_char = in_char;
  assign if1.clear = clear;  assign if1.in_valid = in_valid;  assign if1.in_char = in_char;
  assign if2.clear = clear;  assign if2.in_valid = in_valid;  assign if2.in_char = in_char;

  block_nest_checker #(.DEPTH_W(4), .DELIM(8'h20), .CASE_SENS(1'b0)) u_dut0 (
    .clk(clk), .reset(reset_n), .bus(if0.slave));
  block_nest_checker #(.DEPTH_W(2), .DELIM(8'h20), .CASE_SENS(1'b0)) u_dut1 (
    .clk(clk), .reset(reset_n), .bus(if1.slave));
  block_nest_checker #(.DEPTH_W(4), .DELIM(8'h20), .CASE_SENS(1'b1)) u_dut2 (
    .clk(clk), .reset(reset_n), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    reset_n  = 1'b0;
    #12;
    reset_n  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL reset_balanced got %b exp 1", if0.balanced); end
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b exp 0", if0.error); end
    n_checks++; if (if0.err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovf got %b exp 0", if0.err_ovf); end
  endtask

  task automatic test_basic();
    do_reset();
    send_str("BEGIN");
    n_checks++; if (if0.balanced !== 1'b0) begin n_fail++; $display("FAIL basic_begin_pend_bal got %b exp 0", if0.balanced); end
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL basic_begin_pend_depth got %0d exp 0", if0.depth); end
    send_str(" ");
    n_checks++; if (if0.depth !== 4'd1) begin n_fail++; $display("FAIL basic_depth1 got %0d exp 1", if0.depth); end
    send_str("end");
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL basic_end_pend_bal got %b exp 1", if0.balanced); end
    n_checks++; if (if0.depth !== 4'd1) begin n_fail++; $display("FAIL basic_end_pend_depth got %0d exp 1", if0.depth); end
    send_str(" ");
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL basic_final_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL basic_final_bal got %b exp 1", if0.balanced); end
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL basic_final_err got %b exp 0", if0.error); end
  endtask

  task automatic test_underflow();
    do_reset();
    send_str("end");
    n_checks++; if (if0.balanced !== 1'b0) begin n_fail++; $display("FAIL unf_pend_bal got %b exp 0", if0.balanced); end
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL unf_pend_err got %b exp 0", if0.error); end
    send_str(" ");
    n_checks++; if (if0.error !== 1'b1) begin n_fail++; $display("FAIL unf_err got %b exp 1", if0.error); end
    n_checks++; if (if0.err_ovf !== 1'b0) begin n_fail++; $display("FAIL unf_ovf got %b exp 0", if0.err_ovf); end
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL unf_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.balanced !== 1'b0) begin n_fail++; $display("FAIL unf_bal got %b exp 0", if0.balanced); end
    send_str("begin ");
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL unf_frozen_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.error !== 1'b1) begin n_fail++; $display("FAIL unf_sticky_err got %b exp 1", if0.error); end
    n_checks++; if (if0.balanced !== 1'b0) begin n_fail++; $display("FAIL unf_sticky_bal got %b exp 0", if0.balanced); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_str("begin begin begin ");
    n_checks++; if (if1.depth !== 2'd3) begin n_fail++; $display("FAIL ovf_pre_depth got %0d exp 3", if1.depth); end
    n_checks++; if (if1.error !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_err got %b exp 0", if1.error); end
    send_str("begin ");
    n_checks++; if (if1.error !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", if1.error); end
    n_checks++; if (if1.err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", if1.err_ovf); end
    n_checks++; if (if1.depth !== 2'd3) begin n_fail++; $display("FAIL ovf_depth got %0d exp 3", if1.depth); end
    n_checks++; if (if1.balanced !== 1'b0) begin n_fail++; $display("FAIL ovf_bal got %b exp 0", if1.balanced); end
    n_checks++; if (if0.depth !== 4'd4) begin n_fail++; $display("FAIL ovf_wide_depth got %0d exp 4", if0.depth); end
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_err got %b exp 0", if0.error); end
  endtask

  task automatic test_nonkeywords();
    string s;
    do_reset();
    s = "beginx endx begi en ";
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL nokw_depth[%0d] got %0d exp 0", i, if0.depth); end
      n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL nokw_err[%0d] got %b exp 0", i, if0.error); end
    end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL nokw_bal got %b exp 1", if0.balanced); end
    send_str("ends ");
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL nokw_ends_err got %b exp 0", if0.error); end
  endtask

  task automatic test_case_and_valid();
    do_reset();
    send_str("Begin beg");
    n_checks++; if (if2.balanced !== 1'b1) begin n_fail++; $display("FAIL case_mid_bal got %b exp 1", if2.balanced); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_char  = (k == 1) ? 8'h20 : 8'h78;
    end
    @(posedge clk);
    #1;
    n_checks++; if (if2.depth !== 4'd0) begin n_fail++; $display("FAIL idle_depth got %0d exp 0", if2.depth); end
    n_checks++; if (if2.balanced !== 1'b1) begin n_fail++; $display("FAIL idle_bal got %b exp 1", if2.balanced); end
    send_str("in");
    n_checks++; if (if2.balanced !== 1'b0) begin n_fail++; $display("FAIL case_pend_bal got %b exp 0", if2.balanced); end
    send_str(" ");
    n_checks++; if (if2.depth !== 4'd1) begin n_fail++; $display("FAIL case_sens_depth got %0d exp 1", if2.depth); end
    n_checks++; if (if0.depth !== 4'd2) begin n_fail++; $display("FAIL case_insens_depth got %0d exp 2", if0.depth); end
  endtask

  task automatic test_clear_reset();
    do_reset();
    send_str("begin be");
    n_checks++; if (if0.depth !== 4'd1) begin n_fail++; $display("FAIL clr_pre_depth got %0d exp 1", if0.depth); end
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h20;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL clr_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL clr_bal got %b exp 1", if0.balanced); end
    send_str("gin ");
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL clr_discard_depth got %0d exp 0", if0.depth); end
    send_str("end ");
    n_checks++; if (if0.error !== 1'b1) begin n_fail++; $display("FAIL clr_err_set got %b exp 1", if0.error); end
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL clr_err got %b exp 0", if0.error); end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL clr_err_bal got %b exp 1", if0.balanced); end
    send_str("begin begin ");
    n_checks++; if (if0.depth !== 4'd2) begin n_fail++; $display("FAIL rst_pre_depth got %0d exp 2", if0.depth); end
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 8'h62;
    #2;
    reset_n  = 1'b0;
    #1;
    n_checks++; if (if0.depth !== 4'd0) begin n_fail++; $display("FAIL async_depth got %0d exp 0", if0.depth); end
    n_checks++; if (if0.balanced !== 1'b1) begin n_fail++; $display("FAIL async_bal got %b exp 1", if0.balanced); end
    n_checks++; if (if0.error !== 1'b0) begin n_fail++; $display("FAIL async_err got %b exp 0", if0.error); end
    in_valid = 1'b0;
    #10;
    reset_n  = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_nonkeywords();
    test_case_and_valid();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
